cdr_serial_tx: RTL and testbench

//  Serial NRZ transmitter feeding the CDR model's data_in; one bit per clk.

---
 rtl/cdr_tx_pkg.sv | 25 ++
 rtl/cdr_prbs7.sv | 23 ++
 rtl/cdr_serial_tx.sv | 145 ++++++++++++++
 tb/tb_cdr_serial_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cdr_tx_pkg.sv
// Shared types and constants for the CDR serial transmitter.
package cdr_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    SYNC     = 2'd2,
    DATA     = 2'd3
  } tx_state_e;

  // Training pattern, sent MSB first and repeated: 1,0,0,0,...
  localparam logic [3:0] PREAMBLE_PATTERN = 4'b1000;

  // PRBS7 x^7 + x^6 + 1: feedback taps at p[6] and p[5].
  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdr_prbs7.sv
// PRBS7 keystream generator; key is the bit XORed into the current payload bit.
import cdr_tx_pkg::*;

module cdr_prbs7 (
  input  logic clk,
  input  logic rstn,
  input  logic seed_load,
  input  logic advance,
  output logic key
);

  logic [6:0] p;

  // Reseed has priority; otherwise step once per payload bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          p <= PRBS7_SEED;
    else if (seed_load) p <= PRBS7_SEED;
    else if (advance)   p <= {p[5:0], p[PRBS7_TAP_A] ^ p[PRBS7_TAP_B]};
  end

  assign key = p[6];

endmodule

// File: rtl/cdr_serial_tx.sv
// Serial NRZ framer: preamble -> sync word -> (optionally scrambled) payload.
// The state and counter describe the bit currently on data_out; the
// combinational block computes the bit for the next cycle.
import cdr_tx_pkg::*;

module cdr_serial_tx #(
  parameter int                    WORD_WIDTH    = 8,
  parameter int                    PREAMBLE_BITS = 64,
  parameter int                    SYNC_WIDTH    = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD     = 16'hF628,
  parameter bit                    SCRAMBLE      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  data_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int CNT_MAX = max3(PREAMBLE_BITS, SYNC_WIDTH, WORD_WIDTH);
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 2;

  localparam logic [CNT_W-1:0]      PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0]      SYNC_LAST = CNT_W'(SYNC_WIDTH - 1);
  localparam logic [CNT_W-1:0]      WORD_LAST = CNT_W'(WORD_WIDTH - 1);
  localparam logic [SYNC_WIDTH-1:0] SYNC_MSB  = {1'b1, {(SYNC_WIDTH-1){1'b0}}};

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic                  last_q, last_d;
  logic                  dout_d, ready_d, done_d, urun_d;
  logic                  load, seed_load, advance, key, ks;
  logic [1:0]            ph;
  logic [WORD_WIDTH-1:0] word;

  cdr_prbs7 u_prbs (
    .clk       (clk),
    .rstn      (rstn),
    .seed_load (seed_load),
    .advance   (advance),
    .key       (key)
  );

  // Next-state, next line bit and handshake/pulse generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    shreg_d   = shreg_q;
    last_d    = last_q;
    dout_d    = 1'b0;
    done_d    = 1'b0;
    urun_d    = 1'b0;
    advance   = 1'b0;
    load      = 1'b0;
    ks        = SCRAMBLE ? key : 1'b0;
    ph        = cnt_q[1:0] + 2'd1;
    // A missing word at a boundary becomes an all-zero fill word.
    word      = s_valid ? s_data : '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s_valid) begin
          state_d = PREAMBLE;
          dout_d  = PREAMBLE_PATTERN[3];
        end
      end
      PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = SYNC;
          cnt_d   = '0;
          dout_d  = SYNC_WORD[SYNC_WIDTH-1];
        end else begin
          dout_d = PREAMBLE_PATTERN[2'd3 - ph];
        end
      end
      SYNC: begin
        if (cnt_q == SYNC_LAST) load = 1'b1;
        else dout_d = |(SYNC_WORD & (SYNC_MSB >> (cnt_q + CNT_W'(1))));
      end
      DATA: begin
        if (cnt_q == WORD_LAST) begin
          if (last_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            load = 1'b1;
          end
        end else begin
          dout_d  = shreg_q[WORD_WIDTH-1] ^ ks;
          shreg_d = shreg_q << 1;
          advance = 1'b1;
          done_d  = last_q && (cnt_d == WORD_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
    // Word boundary: s_ready is high this cycle, so this is the handshake.
    if (load) begin
      state_d = DATA;
      cnt_d   = '0;
      shreg_d = word << 1;
      last_d  = s_valid & s_last;
      urun_d  = ~s_valid;
      dout_d  = word[WORD_WIDTH-1] ^ ks;
      advance = 1'b1;
      done_d  = (WORD_WIDTH == 1) && s_valid && s_last;
    end
    ready_d   = (state_d == SYNC && cnt_d == SYNC_LAST) ||
                (state_d == DATA && cnt_d == WORD_LAST && !last_d);
    // Seed lands during the last sync bit, ready for the first payload bit.
    seed_load = (state_d == SYNC && cnt_d == SYNC_LAST);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      data_out   <= 1'b0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      data_out   <= dout_d;
      s_ready    <= ready_d;
      busy       <= (state_d != IDLE);
      frame_done <= done_d;
      underrun   <= urun_d;
    end
  end

endmodule

// File: tb/tb_cdr_serial_tx.sv
// Bench for cdr_serial_tx: scrambled and bypass instances share one source;
// each frame's line bits are predicted from the framing rules.
module tb_cdr_serial_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] s_data;
  logic       s_valid, s_last;
  logic       rdy_s, dout_s, busy_s, done_s, ur_s;
  logic       rdy_p, dout_p, busy_p, done_p, ur_p;

  int errors = 0;
  int checks = 0;

  logic [7:0] words[$];
  logic [7:0] payload[$];
  bit         exp_s[$];
  bit         exp_p[$];

  always #5 clk = ~clk;

  cdr_serial_tx #(.SCRAMBLE(1'b1)) dut_s (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(rdy_s), .data_out(dout_s), .busy(busy_s), .frame_done(done_s), .underrun(ur_s)
  );

  cdr_serial_tx #(.SCRAMBLE(1'b0)) dut_p (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(rdy_p), .data_out(dout_p), .busy(busy_p), .frame_done(done_p), .underrun(ur_p)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // i-th keystream bit of x^7+x^6+1 seeded with all ones.
  function automatic bit prbs_key(input int i);
    logic [6:0] p;
    p = 7'h7F;
    for (int k = 0; k < i; k++) p = {p[5:0], p[6] ^ p[5]};
    return p[6];
  endfunction

  // Expected line for a frame; a fill word of zero replaces boundary 'gap'.
  task automatic build_frame(input int gap);
    logic [15:0] sw;
    payload.delete(); exp_s.delete(); exp_p.delete();
    for (int w = 0; w < words.size(); w++) begin
      if (w == gap) payload.push_back(8'h00);
      payload.push_back(words[w]);
    end
    for (int i = 0; i < 64; i++) begin
      exp_s.push_back(i % 4 == 0); exp_p.push_back(i % 4 == 0);
    end
    sw = 16'hF628;
    for (int i = 15; i >= 0; i--) begin
      exp_s.push_back(sw[i]); exp_p.push_back(sw[i]);
    end
    for (int w = 0; w < payload.size(); w++)
      for (int b = 7; b >= 0; b--) begin
        exp_p.push_back(payload[w][b]);
        exp_s.push_back(payload[w][b] ^ prbs_key(w * 8 + (7 - b)));
      end
  endtask

  // Called at a negedge of an idle cycle; returns at the negedge of the idle
  // cycle that follows the frame, so consecutive calls run back to back.
  task automatic do_frame(input int gap);
    int n, k, L, wi, bnd, nrdy_s, nrdy_p, nur_s, nur_p, jr;
    bit exp_rdy, exp_ur;
    logic [7:0] fb;
    n = words.size();
    build_frame(gap);
    k = payload.size();
    L = exp_s.size();
    wi = 0; bnd = 0; nrdy_s = 0; nrdy_p = 0; nur_s = 0; nur_p = 0; fb = '0;
    s_valid = 1'b1; s_data = words[0]; s_last = (n == 1);
    for (int j = 0; j < L; j++) begin
      @(negedge clk);
      jr = j - 79;
      exp_rdy = (jr >= 0) && (jr % 8 == 0) && (jr / 8 < k);
      exp_ur  = (gap >= 0) && (j == 80 + 8 * gap);
      chk("line_scr", dout_s, exp_s[j]);
      chk("line_raw", dout_p, exp_p[j]);
      chk("busy", {busy_s, busy_p}, 2'b11);
      chk("frame_done", {done_s, done_p}, {2{(j == L - 1)}});
      chk("s_ready", {rdy_s, rdy_p}, {2{exp_rdy}});
      chk("underrun", {ur_s, ur_p}, {2{exp_ur}});
      if (j >= 80 && j < 88) fb = {fb[6:0], dout_s};
      nrdy_s += rdy_s; nrdy_p += rdy_p; nur_s += ur_s; nur_p += ur_p;
      if (rdy_s) begin
        if (bnd == gap) s_valid = 1'b0;
        else begin
          s_valid = 1'b1; s_data = words[wi]; s_last = (wi == n - 1); wi++;
        end
        bnd++;
      end else if (wi >= n) begin
        s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'b0;
      end else begin
        s_valid = 1'($urandom); s_data = 8'($urandom); s_last = 1'($urandom);
      end
    end
    @(negedge clk);
    chk("idle_line", {dout_s, dout_p}, 2'b00);
    chk("idle_busy", {busy_s, busy_p}, 2'b00);
    chk("ready_count_scr", nrdy_s, k);
    chk("ready_count_raw", nrdy_p, k);
    chk("underrun_count", nur_s + nur_p, (gap >= 0) ? 2 : 0);
    chk("first_byte_scr", fb, payload[0] ^ 8'hFE);
  endtask

  initial begin
    rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {rdy_s, dout_s, busy_s, done_s, ur_s,
                       rdy_p, dout_p, busy_p, done_p, ur_p}, 0);
    rstn = 1'b1;

    // Idle line with no source data.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_quiet", {rdy_s, dout_s, busy_s, rdy_p, dout_p, busy_p}, 0);
    end

    // Single word A5, last.
    words = '{8'hA5};
    do_frame(-1);

    // Scrambled 00 then FF; back to back with the previous frame.
    words = '{8'h00, 8'hFF};
    do_frame(-1);

    // Three words, source stalls at the second boundary.
    words = '{8'h3C, 8'h81, 8'h7E};
    do_frame(1);

    // Reset during the sync word.
    s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (69) @(negedge clk);
    chk("in_sync_busy", {busy_s, busy_p}, 2'b11);
    #2 rstn = 1'b0;
    #1;
    chk("abort_line", {dout_s, dout_p}, 2'b00);
    chk("abort_busy", {busy_s, busy_p}, 2'b00);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    words = '{8'hC3, 8'h19};
    do_frame(-1);

    // Random frames, occasionally with a stalled boundary.
    for (int f = 0; f < 6; f++) begin
      int n, gap;
      n = $urandom_range(1, 4);
      words.delete();
      for (int w = 0; w < n; w++) words.push_back(8'($urandom));
      gap = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      do_frame(gap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
